udp_result_reader: RTL and testbench



---
 rtl/udp_result_reader_pkg.sv | 18 +
 rtl/udp_result_reader_if.sv | 25 ++
 rtl/udp_result_reader_result_word_serializer.sv | 51 +++++
 rtl/udp_result_reader.sv | 142 ++++++++++++++
 tb/tb_udp_result_reader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_result_reader_pkg.sv
// Shared constants and state encoding for the UDP result reader.
package udp_result_reader_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned WORD_W     = 512;
    localparam int unsigned BEAT_W     = 32;
    localparam int unsigned BEATS      = WORD_W / BEAT_W;
    localparam int unsigned BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/udp_result_reader_if.sv
// Valid/ready beat stream towards the UDP transmit path.
interface udp_result_reader_if import udp_result_reader_pkg::*; #(
    parameter int unsigned DATA_W = BEAT_W
) ();

    logic [DATA_W-1:0] tx_data_o;
    logic              tx_valid_o;
    logic              tx_ready_i;
    logic              tx_last_o;

    modport master (
        output tx_data_o,
        output tx_valid_o,
        output tx_last_o,
        input  tx_ready_i
    );

    modport slave (
        input  tx_data_o,
        input  tx_valid_o,
        input  tx_last_o,
        output tx_ready_i
    );

endinterface

// File: rtl/udp_result_reader_result_word_serializer.sv
// Parallel-in/serial-out register: loads one result word, emits it LSB beat first.
module udp_result_reader_result_word_serializer #(
    parameter int unsigned WORD_W = 512,
    parameter int unsigned BEAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last_word,
    input  logic              shift,
    output logic [BEAT_W-1:0] beat_data,
    output logic              beat_last,
    output logic              last_beat_c
);

    localparam int unsigned BEATS = WORD_W / BEAT_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [WORD_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              word_last_q;
    logic              last_q;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Load a word, then shift one beat out per accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            word_last_q <= 1'b0;
            last_q      <= 1'b0;
        end else if (load) begin
            shift_q     <= load_data;
            cnt_q       <= '0;
            word_last_q <= load_last_word;
            last_q      <= load_last_word && (BEATS == 1);
        end else if (shift) begin
            shift_q     <= shift_q >> BEAT_W;
            cnt_q       <= cnt_inc;
            last_q      <= word_last_q && (cnt_inc == CNT_W'(BEATS - 1));
        end
    end

    assign beat_data   = shift_q[BEAT_W-1:0];
    assign beat_last   = last_q;
    assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/udp_result_reader.sv
// Reads runs of result words from the SRAM UDP port and streams them as beats.
module udp_result_reader #(
    parameter int unsigned MEM_ADDR_BIT_WIDTH         = udp_result_reader_pkg::ADDR_W,
    parameter int unsigned CNNA_OUTPUT_DATA_BIT_WIDTH = udp_result_reader_pkg::WORD_W,
    parameter int unsigned UDP_DATA_BIT_WIDTH         = udp_result_reader_pkg::BEAT_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_i,
    input  logic [MEM_ADDR_BIT_WIDTH-1:0]         start_addr_i,
    input  logic [MEM_ADDR_BIT_WIDTH:0]           num_words_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    input  logic                                  cnna_mem_write_en_i,
    output logic                                  udp_mem_read_en_o,
    output logic [MEM_ADDR_BIT_WIDTH-1:0]         udp_mem_address_o,
    input  logic [CNNA_OUTPUT_DATA_BIT_WIDTH-1:0] data_to_udp_i,
    udp_result_reader_if.master                   tx
);

    import udp_result_reader_pkg::*;

    localparam int unsigned AW    = MEM_ADDR_BIT_WIDTH;
    localparam int unsigned CNT_W = MEM_ADDR_BIT_WIDTH + 1;

    state_e        state_q;
    state_e        state_d;
    logic [AW-1:0] addr_q;
    logic [CNT_W-1:0] words_q;
    logic          read_en_q;
    logic          busy_q;
    logic          done_q;
    logic          valid_q;

    logic          hs_c;
    logic          last_beat_c;
    logic          zero_start_c;
    logic          word_adv_c;
    logic [UDP_DATA_BIT_WIDTH-1:0] beat_data;
    logic          beat_last;

    assign hs_c = valid_q & tx.tx_ready_i;

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_d      = state_q;
        zero_start_c = 1'b0;
        word_adv_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (num_words_i != CNT_W'(0)) begin
                        state_d = ST_READ;
                    end else begin
                        zero_start_c = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (!cnna_mem_write_en_i) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (hs_c && last_beat_c) begin
                    if (words_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_READ;
                        word_adv_c = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address/word counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            words_q   <= '0;
            read_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && state_d == ST_READ) begin
                addr_q  <= start_addr_i;
                words_q <= num_words_i;
            end else if (word_adv_c) begin
                addr_q  <= addr_q + AW'(1);
                words_q <= words_q - CNT_W'(1);
            end
            read_en_q <= (state_d == ST_READ);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE) || zero_start_c;
            valid_q   <= (state_d == ST_SEND);
        end
    end

    udp_result_reader_result_word_serializer #(
        .WORD_W (CNNA_OUTPUT_DATA_BIT_WIDTH),
        .BEAT_W (UDP_DATA_BIT_WIDTH)
    ) u_serializer (
        .clk            (clk),
        .rst            (rst),
        .load           (state_q == ST_LATCH),
        .load_data      (data_to_udp_i),
        .load_last_word (words_q == CNT_W'(1)),
        .shift          (hs_c),
        .beat_data      (beat_data),
        .beat_last      (beat_last),
        .last_beat_c    (last_beat_c)
    );

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign udp_mem_read_en_o = read_en_q;
    assign udp_mem_address_o = addr_q;
    assign tx.tx_data_o      = beat_data;
    assign tx.tx_valid_o     = valid_q;
    assign tx.tx_last_o      = beat_last;

endmodule

// File: tb/tb_udp_result_reader.sv
// Bench for udp_result_reader: SRAM model plus queue-based expected stream.
module tb_udp_result_reader;

    import udp_result_reader_pkg::*;

    localparam int unsigned NB = WORD_W / BEAT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [ADDR_W-1:0] start_addr_i;
    logic [ADDR_W:0]   num_words_i;
    logic              busy_o;
    logic              done_o;
    logic              cnna_mem_write_en_i;
    logic              udp_mem_read_en_o;
    logic [ADDR_W-1:0] udp_mem_address_o;
    logic [WORD_W-1:0] rdata;

    udp_result_reader_if tx_if ();

    udp_result_reader dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start_i),
        .start_addr_i        (start_addr_i),
        .num_words_i         (num_words_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .cnna_mem_write_en_i (cnna_mem_write_en_i),
        .udp_mem_read_en_o   (udp_mem_read_en_o),
        .udp_mem_address_o   (udp_mem_address_o),
        .data_to_udp_i       (rdata),
        .tx                  (tx_if)
    );

    always #5 clk = ~clk;

    // SRAM UDP port: write strobe wins, read data appears the next cycle.
    logic [WORD_W-1:0] mem [256];
    always @(posedge clk) begin
        if (udp_mem_read_en_o && !cnna_mem_write_en_i) rdata <= mem[udp_mem_address_o];
    end

    int total = 0;
    int bad   = 0;
    int rd_cycles, valid_cycles, done_cnt, done_n;

    logic [BEAT_W-1:0] obs_data[$], exp_data[$];
    logic              obs_last[$], exp_last[$];
    logic [ADDR_W-1:0] obs_addr[$], exp_addr[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Log what the edge is about to accept, advance one clock, check stall stability.
    task automatic tick();
        logic              stall;
        logic [BEAT_W-1:0] pd;
        logic              pl;
        stall = tx_if.tx_valid_o && !tx_if.tx_ready_i && !rst;
        pd    = tx_if.tx_data_o;
        pl    = tx_if.tx_last_o;
        if (tx_if.tx_valid_o && tx_if.tx_ready_i) begin
            obs_data.push_back(tx_if.tx_data_o);
            obs_last.push_back(tx_if.tx_last_o);
        end
        if (udp_mem_read_en_o) rd_cycles++;
        if (udp_mem_read_en_o && !cnna_mem_write_en_i) obs_addr.push_back(udp_mem_address_o);
        if (tx_if.tx_valid_o) valid_cycles++;
        if (done_o) done_cnt++;
        @(posedge clk);
        #1;
        if (stall) begin
            chk("hold_valid", 64'(tx_if.tx_valid_o), 64'd1);
            chk("hold_data", 64'(tx_if.tx_data_o), 64'(pd));
            chk("hold_last", 64'(tx_if.tx_last_o), 64'(pl));
        end
    endtask

    // Reference stream: consecutive words (address wraps), LSB beat first.
    task automatic build_expected(input logic [ADDR_W-1:0] sa, input int nw);
        logic [ADDR_W-1:0] a;
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        for (int w = 0; w < nw; w++) begin
            a = ADDR_W'(sa + w);
            exp_addr.push_back(a);
            for (int k = 0; k < int'(NB); k++) begin
                exp_data.push_back(mem[a][BEAT_W*k +: BEAT_W]);
                exp_last.push_back((w == nw - 1) && (k == int'(NB) - 1));
            end
        end
    endtask

    function automatic logic ready_for(input int mode, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (n % 2 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic clear_obs();
        obs_data.delete(); obs_last.delete(); obs_addr.delete();
        rd_cycles = 0; valid_cycles = 0; done_cnt = 0;
    endtask

    // One run: start pulse, optional write collisions and a stray start, wait for done.
    task automatic do_run(input logic [ADDR_W-1:0] sa, input int nw, input int mode,
                          input int wr_from, input int wr_len, input int restart_n);
        int n;
        int budget;
        clear_obs();
        build_expected(sa, nw);
        budget = 400 * (nw + 1);
        start_addr_i = sa;
        num_words_i = (ADDR_W + 1)'(nw);
        start_i = 1'b1;
        cnna_mem_write_en_i = 1'b0;
        tx_if.tx_ready_i = ready_for(mode, 0);
        tick();
        start_i = 1'b0;
        n = 1;
        while (!done_o && n < budget) begin
            tx_if.tx_ready_i = ready_for(mode, n);
            cnna_mem_write_en_i = (n >= wr_from && n < wr_from + wr_len) ||
                                  (mode == 2 && $urandom_range(0, 3) == 0);
            if (n == restart_n) begin
                start_i = 1'b1;
                start_addr_i = ~sa;
                num_words_i = (ADDR_W + 1)'(5);
            end
            tick();
            start_i = 1'b0;
            n++;
        end
        done_n = n;
        chk("done_seen", 64'(done_o), 64'd1);
        tx_if.tx_ready_i = 1'b1;
        cnna_mem_write_en_i = 1'b0;
        tick();
        tick();
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_done", 64'(done_o), 64'd0);
    endtask

    task automatic check_stream(input string tag);
        int dm, lm, am;
        dm = 0; lm = 0; am = 0;
        chk({tag, "_beats"}, 64'(obs_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            if (obs_data[i] !== exp_data[i]) dm++;
            if (obs_last[i] !== exp_last[i]) lm++;
        end
        chk({tag, "_data_err"}, 64'(dm), 64'd0);
        chk({tag, "_last_err"}, 64'(lm), 64'd0);
        chk({tag, "_reads"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            if (obs_addr[i] !== exp_addr[i]) am++;
        end
        chk({tag, "_addr_err"}, 64'(am), 64'd0);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_rden"}, 64'(udp_mem_read_en_o), 64'd0);
        chk({tag, "_addr"}, 64'(udp_mem_address_o), 64'd0);
        chk({tag, "_data"}, 64'(tx_if.tx_data_o), 64'd0);
        chk({tag, "_valid"}, 64'(tx_if.tx_valid_o), 64'd0);
        chk({tag, "_last"}, 64'(tx_if.tx_last_o), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start_i = 1'b0;
        start_addr_i = '0;
        num_words_i = '0;
        cnna_mem_write_en_i = 1'b0;
        tx_if.tx_ready_i = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int k = 0; k < int'(NB); k++) mem[a][BEAT_W*k +: BEAT_W] = $urandom;
        end
        for (int k = 0; k < int'(NB); k++) mem[16][BEAT_W*k +: BEAT_W] = 32'h03020100 + 32'(k) * 32'h04040404;

        clear_obs();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single word, full-rate sink.
        do_run(8'h10, 1, 0, 0, 0, 0);
        check_stream("one_word");
        chk("one_word_done_cycle", 64'(done_n), 64'd19);
        chk("one_word_rd_cycles", 64'(rd_cycles), 64'd1);
        chk("one_word_valid_cycles", 64'(valid_cycles), 64'(NB));

        // Three words with 1010 ready pattern.
        do_run(8'h10, 3, 1, 0, 0, 0);
        check_stream("toggle_ready");

        // Write strobe blocks the read for three cycles.
        do_run(8'h20, 1, 0, 1, 3, 0);
        check_stream("collision");
        chk("collision_rd_cycles", 64'(rd_cycles), 64'd4);
        chk("collision_done_cycle", 64'(done_n), 64'd22);

        // Address wrap 0xFF -> 0x00.
        do_run(8'hFF, 2, 0, 0, 0, 0);
        check_stream("wrap");
        chk("wrap_addr1", 64'(obs_addr.size() > 1 ? obs_addr[1] : 8'hAA), 64'd0);

        // Zero-length run.
        do_run(8'h30, 0, 0, 0, 0, 0);
        chk("zero_done_cycle", 64'(done_n), 64'd1);
        chk("zero_rd_cycles", 64'(rd_cycles), 64'd0);
        chk("zero_valid_cycles", 64'(valid_cycles), 64'd0);
        chk("zero_done_cnt", 64'(done_cnt), 64'd1);

        // Stray start while sending is ignored.
        do_run(8'h40, 2, 0, 0, 0, 8);
        check_stream("busy_start");
        chk("busy_start_done_cycle", 64'(done_n), 64'd37);

        // Reset while beat 7 of the second word is on the bus.
        clear_obs();
        start_addr_i = 8'h50;
        num_words_i = 9'd3;
        start_i = 1'b1;
        tx_if.tx_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 1;
        while (obs_data.size() < int'(NB) + 7 && n < 500) begin
            tick();
            n++;
        end
        chk("rst_reach_beat", 64'(obs_data.size()), 64'(NB + 7));
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        done_cnt = 0;
        repeat (5) tick();
        chk("midrst_no_done", 64'(done_cnt), 64'd0);
        chk("midrst_idle_busy", 64'(busy_o), 64'd0);
        do_run(8'h80, 1, 0, 0, 0, 0);
        check_stream("after_rst");
        chk("after_rst_done_cycle", 64'(done_n), 64'd19);

        // Random runs with random backpressure and write collisions.
        for (int r = 0; r < 6; r++) begin
            do_run(ADDR_W'($urandom), int'($urandom_range(1, 4)), 2, 0, 0, 0);
            check_stream("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
